// File: rtl/emu_ctrl_pkg.sv
// Shared definitions for the emulation step controller: state encoding,
// wrapper byte addresses and stimulus bit positions.
package emu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_WRITE  = 4'd1,
    ST_LOAD   = 4'd2,
    ST_SETTLE = 4'd3,
    ST_GET    = 4'd4,
    ST_RD0    = 4'd5,
    ST_RD1    = 4'd6,
    ST_RD2    = 4'd7,
    ST_RSP    = 4'd8
  } state_t;

  localparam logic [2:0] ADDR_STIM = 3'd0;
  localparam logic [2:0] ADDR_OUT0 = 3'd0;
  localparam logic [2:0] ADDR_OUT1 = 3'd1;

  // Bit positions inside the stimulus byte {----, clk, reset, up, down}
  localparam int STIM_BIT_CLK = 3;
  localparam int STIM_BIT_RST = 2;
  localparam int STIM_BIT_UP  = 1;
  localparam int STIM_BIT_DN  = 0;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/emu_step_ctrl_if.sv
// Host-side command/response handshake of the emulation step controller.
interface emu_step_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_stim;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;

  modport master (
    output cmd_valid, cmd_stim, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_stim, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/emu_step_ctrl.sv
// Drives one emulation step through the wrapper: write stimulus, load,
// settle, capture, read back two output bytes and hand them to the host.
//
// state  | meaning
// IDLE   | waiting for a host command
// WRITE  | stimulus byte presented on the wrapper bus
// LOAD   | one-cycle load strobe
// SETTLE | wait SETTLE_CYC cycles for the emulated design to settle
// GET    | one-cycle capture strobe
// RD0    | address output byte 0
// RD1    | address output byte 1, take byte 0
// RD2    | take byte 1
// RSP    | result offered to host until accepted
module emu_step_ctrl
  import emu_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2,
  parameter logic [2:0]  STIM_ADDR  = ADDR_STIM,
  parameter logic [2:0]  OUT0_ADDR  = ADDR_OUT0,
  parameter logic [2:0]  OUT1_ADDR  = ADDR_OUT1
) (
  input  logic        clk,
  input  logic        reset,
  emu_step_ctrl_if.slave host,
  output logic [15:0] step_cnt,
  output logic        busy,
  output logic [7:0]  Din_emu,
  output logic [2:0]  Addr_emu,
  output logic        load_emu,
  output logic        get_emu,
  input  logic [7:0]  Dout_emu
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  logic [7:0]        stim_q;
  logic [WAIT_W-1:0] wait_q;
  logic [15:0]       rsp_q;
  logic [15:0]       step_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Readback bytes arrive one cycle after their address, hence RD1/RD2 capture
  always_ff @(posedge clk) begin
    if (reset) begin
      stim_q     <= '0;
      wait_q     <= '0;
      rsp_q      <= '0;
      step_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE:   if (host.cmd_valid) stim_q <= host.cmd_stim;
        ST_LOAD:   wait_q <= WAIT_INIT;
        ST_SETTLE: if (wait_q != '0) wait_q <= wait_q - 1'b1;
        ST_RD1:    rsp_q[15:8] <= Dout_emu;
        ST_RD2:    rsp_q[7:0]  <= Dout_emu;
        ST_RSP:    if (host.rsp_ready) step_cnt_q <= step_cnt_q + 16'd1;
        default:   ;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    host.cmd_ready = 1'b0;
    host.rsp_valid = 1'b0;
    busy           = 1'b1;
    Addr_emu       = '0;
    load_emu       = 1'b0;
    get_emu        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        host.cmd_ready = 1'b1;
        busy           = 1'b0;
        if (host.cmd_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        Addr_emu = STIM_ADDR;
        state_d  = ST_LOAD;
      end
      ST_LOAD: begin
        Addr_emu = STIM_ADDR;
        load_emu = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        Addr_emu = STIM_ADDR;
        if (wait_q == '0) state_d = ST_GET;
      end
      ST_GET: begin
        Addr_emu = STIM_ADDR;
        get_emu  = 1'b1;
        state_d  = ST_RD0;
      end
      ST_RD0: begin
        Addr_emu = OUT0_ADDR;
        state_d  = ST_RD1;
      end
      ST_RD1: begin
        Addr_emu = OUT1_ADDR;
        state_d  = ST_RD2;
      end
      ST_RD2: begin
        Addr_emu = OUT1_ADDR;
        state_d  = ST_RSP;
      end
      ST_RSP: begin
        host.rsp_valid = 1'b1;
        if (host.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign host.rsp_data = rsp_q;
  assign Din_emu       = stim_q;
  assign step_cnt      = step_cnt_q;

endmodule
